// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the exhaustive truth-table sweeper.
package truth_table_sweeper_pkg;

   // Default sweep geometry (six inputs A..F driving one output Y).
   localparam int unsigned N_IN_DEFAULT = 6;
   localparam int unsigned DEPTH        = 2**N_IN_DEFAULT;

   // Settle counter width; covers the full legal SETTLE range 1..255.
   localparam int unsigned WCNT_W = 8;

   // Sweeper control states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit position of each block input within vec; A is the MSB.
   localparam int unsigned VEC_BIT_A = 5;
   localparam int unsigned VEC_BIT_B = 4;
   localparam int unsigned VEC_BIT_C = 3;
   localparam int unsigned VEC_BIT_D = 2;
   localparam int unsigned VEC_BIT_E = 1;
   localparam int unsigned VEC_BIT_F = 0;

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives every input combination onto vec, waits SETTLE cycles per vector,
// captures y into table_out and counts captured ones.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned N_IN   = 6,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 y,
   output logic [N_IN-1:0]      vec,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        ones_cnt
);

   localparam int unsigned SWEEP_DEPTH = 2**N_IN;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(SWEEP_DEPTH - 1);

   state_e                 state_q, state_d;
   logic [N_IN-1:0]        vec_q, vec_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [SWEEP_DEPTH-1:0] table_q, table_d;
   logic [N_IN:0]          ones_q, ones_d;
   logic [WCNT_W-1:0]      wcnt_q, wcnt_d;

   // Next-state: accept start in IDLE, settle/capture/advance in WAIT,
   // single-cycle DONE back to IDLE.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      table_d = table_q;
      ones_d  = ones_q;
      wcnt_d  = wcnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WAIT;
               busy_d  = 1'b1;
               vec_d   = '0;
               wcnt_d  = '0;
               table_d = '0;
               ones_d  = '0;
            end
         end

         ST_WAIT: begin
            if (wcnt_q != WCNT_LAST) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end else begin
               table_d[vec_q] = y;
               ones_d         = ones_q + (N_IN+1)'(y);
               wcnt_d         = '0;
               if (vec_q == VEC_LAST) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  vec_d   = '0;
               end else begin
                  vec_d = vec_q + N_IN'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            vec_d   = '0;
            wcnt_d  = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= '0;
         ones_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         table_q <= table_d;
         ones_q  <= ones_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign vec       = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign table_out = table_q;
   assign ones_cnt  = ones_q;

endmodule
